// File: rtl/nf10_axis_rr_input_arbiter.sv
// nf10_axis_rr_input_arbiter
// Packet-atomic round-robin arbiter in front of a shared 256->64 AXI4-Stream
// width converter. One input is granted per packet. The grant is held until
// that input's tlast handshake, and then the priority rotates past the winner.
module nf10_axis_rr_input_arbiter #(
    parameter int C_NUM_INPUTS  = 4,
    parameter int C_DATA_WIDTH  = 256,
    parameter int C_TUSER_WIDTH = 128,
    parameter int C_IDX_WIDTH   = 2
) (
    input  logic                                       axi_aclk,
    input  logic                                       axi_reset,

    input  logic [C_NUM_INPUTS*C_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [C_NUM_INPUTS*(C_DATA_WIDTH/8)-1:0]   s_axis_tstrb,
    input  logic [C_NUM_INPUTS*C_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic [C_NUM_INPUTS-1:0]                    s_axis_tvalid,
    input  logic [C_NUM_INPUTS-1:0]                    s_axis_tlast,
    output logic [C_NUM_INPUTS-1:0]                    s_axis_tready,

    output logic [C_DATA_WIDTH-1:0]                    m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]                  m_axis_tstrb,
    output logic [C_TUSER_WIDTH-1:0]                   m_axis_tuser,
    output logic                                       m_axis_tvalid,
    input  logic                                       m_axis_tready,
    output logic                                       m_axis_tlast,

    output logic [C_NUM_INPUTS-1:0]                    grant_onehot
);

    localparam int C_STRB_WIDTH = C_DATA_WIDTH / 8;
    localparam int C_IDX_SPAN   = 2 ** C_IDX_WIDTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [C_IDX_WIDTH-1:0]   grant_q, grant_d;
    logic [C_IDX_WIDTH-1:0]   last_grant_q, last_grant_d;

    // The valid vector is widened to the full index range so that any grant
    // index can select a bit. Indices at or above C_NUM_INPUTS read as idle.
    logic [C_IDX_SPAN-1:0]    valid_ext;
    logic [C_IDX_WIDTH-1:0]   scan_idx;
    logic [C_IDX_WIDTH-1:0]   pick_idx;
    logic                     pick_found;

    assign valid_ext = C_IDX_SPAN'(s_axis_tvalid);

    // Rotating-priority search. It starts one past the last winner and wraps
    // at C_NUM_INPUTS, so the input served most recently is checked last.
    always_comb begin
        // NOTE: every signal written here gets a default before any branch.
        // Without that, a path that skips an assignment would infer a latch.
        scan_idx   = last_grant_q;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int k = 0; k < C_NUM_INPUTS; k++) begin
            // NOTE: blocking '=' is intended in combinational logic. scan_idx
            // advances step by step within one evaluation.
            if (scan_idx == C_IDX_WIDTH'(C_NUM_INPUTS - 1)) begin
                scan_idx = '0;
            end else begin
                scan_idx = scan_idx + C_IDX_WIDTH'(1);
            end
            if (!pick_found && valid_ext[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    // Next-state logic. The winner is registered on the way out of IDLE.
    // The grant is released only by the tlast handshake.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output mux. In SEND it passes the granted input through with zero
    // latency. In IDLE, or for an index with no matching input, every output
    // reads zero.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        grant_onehot  = '0;
        if (state_q == ST_SEND) begin
            for (int i = 0; i < C_NUM_INPUTS; i++) begin
                if (grant_q == C_IDX_WIDTH'(i)) begin
                    m_axis_tdata     = s_axis_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH];
                    m_axis_tstrb     = s_axis_tstrb[i*C_STRB_WIDTH +: C_STRB_WIDTH];
                    m_axis_tuser     = s_axis_tuser[i*C_TUSER_WIDTH +: C_TUSER_WIDTH];
                    m_axis_tvalid    = s_axis_tvalid[i];
                    m_axis_tlast     = s_axis_tlast[i];
                    s_axis_tready[i] = m_axis_tready;
                    grant_onehot[i]  = 1'b1;
                end
            end
        end
    end

    // State registers. After reset, last_grant points at the top input, so
    // input 0 has first priority.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= C_IDX_WIDTH'(C_NUM_INPUTS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_nf10_axis_rr_input_arbiter.sv
// tb_nf10_axis_rr_input_arbiter
// Directed bench for the round-robin input arbiter. A packet-level model
// predicts every output on every cycle. The handshake log is checked
// against hand-computed cycle/tag/grant tables.
module tb_nf10_axis_rr_input_arbiter;

    localparam int N  = 4;
    localparam int DW = 256;
    localparam int UW = 128;
    localparam int SW = DW / 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic [SW-1:0] strb;
        logic          last;
    } beat_t;

    typedef struct {
        int            cyc;
        logic [15:0]   tag;
        logic [N-1:0]  gnt;
        logic [UW-1:0] user;
    } hs_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;

    logic [N*DW-1:0]  s_tdata;
    logic [N*SW-1:0]  s_tstrb;
    logic [N*UW-1:0]  s_tuser;
    logic [N-1:0]     s_tvalid;
    logic [N-1:0]     s_tlast;
    logic [N-1:0]     s_tready;
    logic [DW-1:0]    m_tdata;
    logic [SW-1:0]    m_tstrb;
    logic [UW-1:0]    m_tuser;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tlast;
    logic [N-1:0]     grant_onehot;

    // Upstream source state: the head beat of each input's queue.
    beat_t            src_q [N][$];
    logic [DW-1:0]    cur_data [N];
    logic [UW-1:0]    cur_user [N];
    logic [SW-1:0]    cur_strb [N];
    logic [N-1:0]     cur_last;
    logic [N-1:0]     have;
    logic [N-1:0]     hold;

    int               compared   = 0;
    int               mismatched = 0;
    int               cyc        = 0;
    int               base       = 0;
    hs_t              hs_log[$];

    // Model: owner = input holding the packet grant (-1 = arbitrating).
    int               mdl_owner  = -1;
    int               mdl_last   = N - 1;

    nf10_axis_rr_input_arbiter #(
        .C_NUM_INPUTS (N),
        .C_DATA_WIDTH (DW),
        .C_TUSER_WIDTH(UW),
        .C_IDX_WIDTH  (2)
    ) dut (
        .axi_aclk      (clk),
        .axi_reset     (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .grant_onehot  (grant_onehot)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Flatten the per-input source state onto the DUT buses.
    always_comb begin
        s_tdata = '0;
        s_tstrb = '0;
        s_tuser = '0;
        for (int i = 0; i < N; i++) begin
            s_tdata[i*DW +: DW] = cur_data[i];
            s_tstrb[i*SW +: SW] = cur_strb[i];
            s_tuser[i*UW +: UW] = cur_user[i];
        end
        s_tvalid = have & ~hold;
        s_tlast  = cur_last;
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (((v >> c) & N'(1)) != '0) return c;
        end
        return -1;
    endfunction

    // Per-cycle compare against the packet-level model, sampled mid-cycle.
    always @(negedge clk) begin
        logic [DW-1:0] e_data;
        logic [SW-1:0] e_strb;
        logic [UW-1:0] e_user;
        logic          e_valid;
        logic          e_last;
        logic [N-1:0]  e_ready;
        logic [N-1:0]  e_gnt;
        e_data = '0; e_strb = '0; e_user = '0;
        e_valid = 1'b0; e_last = 1'b0; e_ready = '0; e_gnt = '0;
        if (rst) begin
            mdl_owner = -1;
            mdl_last  = N - 1;
        end else if (mdl_owner >= 0) begin
            e_data  = cur_data[mdl_owner];
            e_strb  = cur_strb[mdl_owner];
            e_user  = cur_user[mdl_owner];
            e_valid = s_tvalid[mdl_owner];
            e_last  = s_tlast[mdl_owner];
            e_gnt   = N'(1) << mdl_owner;
            e_ready = m_tready ? e_gnt : '0;
        end
        check("m_tvalid", DW'(m_tvalid), DW'(e_valid));
        check("m_tlast", DW'(m_tlast), DW'(e_last));
        check("m_tdata", m_tdata, e_data);
        check("m_tstrb", DW'(m_tstrb), DW'(e_strb));
        check("m_tuser", DW'(m_tuser), DW'(e_user));
        check("s_tready", DW'(s_tready), DW'(e_ready));
        check("grant_onehot", DW'(grant_onehot), DW'(e_gnt));
        check("s_tready_onehot0", DW'($onehot0(s_tready)), DW'(1));
        if (!rst) begin
            if (m_tvalid && m_tready) begin
                hs_log.push_back('{cyc: cyc + 1, tag: m_tdata[15:0], gnt: grant_onehot, user: m_tuser});
            end
            // Advance the model to the state after the coming rising edge.
            if (mdl_owner < 0) begin
                mdl_owner = rr_pick(mdl_last, s_tvalid);
            end else if (s_tvalid[mdl_owner] && m_tready && s_tlast[mdl_owner]) begin
                mdl_last  = mdl_owner;
                mdl_owner = -1;
            end
        end
    end

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                cur_data[i] = src_q[i][0].data;
                cur_user[i] = src_q[i][0].user;
                cur_strb[i] = src_q[i][0].strb;
                cur_last[i] = src_q[i][0].last;
                have[i]     = 1'b1;
            end else begin
                cur_data[i] = '0;
                cur_user[i] = '0;
                cur_strb[i] = '0;
                cur_last[i] = 1'b0;
                have[i]     = 1'b0;
            end
        end
    endtask

    // One clock: note handshakes mid-cycle, then pop consumed beats after the edge.
    task automatic step();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        refresh();
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    // Tag layout in tdata[15:0]: {src[7:0], pkt[3:0], beat[3:0]}.
    task automatic load_pkt(input int src, input int pkt, input int beats,
                            input bit use_user, input logic [UW-1:0] user);
        for (int b = 0; b < beats; b++) begin
            beat_t       bt;
            logic [15:0] tag;
            tag     = {8'(src), 4'(pkt), 4'(b)};
            bt.data = {{30{8'h5A}}, tag};
            bt.user = use_user ? user : {8{tag}};
            bt.strb = {tag, ~tag};
            bt.last = (b == beats - 1);
            src_q[src].push_back(bt);
        end
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) src_q[i].delete();
    endtask

    task automatic check_hs(input string name, input int idx, input int rel,
                            input logic [15:0] tag, input logic [N-1:0] gnt);
        if (idx >= hs_log.size()) begin
            compared++;
            mismatched++;
            $display("FAIL %s: handshake %0d missing (only %0d seen)", name, idx, hs_log.size());
        end else begin
            check({name, "_cycle"}, DW'(hs_log[idx].cyc - base), DW'(rel));
            check({name, "_tag"}, DW'(hs_log[idx].tag), DW'(tag));
            check({name, "_grant"}, DW'(hs_log[idx].gnt), DW'(gnt));
        end
    endtask

    initial begin
        logic [UW-1:0] dead_user;
        dead_user = 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0001;
        m_tready  = 1'b1;
        hold      = '0;
        refresh();
        run(2);

        // T1: inputs 0 and 2 with 3-beat packets, loaded during reset.
        load_pkt(0, 0, 3, 1'b0, '0);
        load_pkt(2, 0, 3, 1'b0, '0);
        refresh();
        step();
        rst = 1'b0;
        base = cyc;
        hs_log.delete();
        run(10);
        check("t1_count", DW'(hs_log.size()), DW'(6));
        check_hs("t1_b0", 0, 2, 16'h0000, 4'b0001);
        check_hs("t1_b1", 1, 3, 16'h0001, 4'b0001);
        check_hs("t1_b2", 2, 4, 16'h0002, 4'b0001);
        check_hs("t1_b3", 3, 6, 16'h0200, 4'b0100);
        check_hs("t1_b4", 4, 7, 16'h0201, 4'b0100);
        check_hs("t1_b5", 5, 8, 16'h0202, 4'b0100);

        // T2: all inputs continuously valid with 1-beat packets, from reset.
        rst = 1'b1;
        flush();
        for (int i = 0; i < N; i++) begin
            load_pkt(i, 0, 1, 1'b0, '0);
            load_pkt(i, 1, 1, 1'b0, '0);
        end
        refresh();
        step();
        rst = 1'b0;
        base = cyc;
        hs_log.delete();
        run(20);
        check("t2_count", DW'(hs_log.size()), DW'(8));
        for (int k = 0; k < 8; k++) begin
            check_hs("t2", k, 2 + 2 * k, {8'(k % 4), 4'(k / 4), 4'h0}, 4'(1 << (k % 4)));
        end

        // T3: input 1 sends 4 beats while m_tready toggles 1,0,1,0...
        hs_log.delete();
        load_pkt(1, 0, 4, 1'b0, '0);
        refresh();
        base = cyc;
        for (int j = 0; j < 14; j++) begin
            m_tready = (j % 2 == 0);
            step();
        end
        m_tready = 1'b1;
        check("t3_count", DW'(hs_log.size()), DW'(4));
        check_hs("t3_b0", 0, 3, 16'h0100, 4'b0010);
        check_hs("t3_b1", 1, 5, 16'h0101, 4'b0010);
        check_hs("t3_b2", 2, 7, 16'h0102, 4'b0010);
        check_hs("t3_b3", 3, 9, 16'h0103, 4'b0010);

        // T4: input 3 drops tvalid for 5 cycles after beat 1; input 0 waits.
        hs_log.delete();
        load_pkt(3, 0, 4, 1'b0, '0);
        load_pkt(0, 1, 2, 1'b0, '0);
        refresh();
        base = cyc;
        run(3);
        hold[3] = 1'b1;
        run(5);
        hold[3] = 1'b0;
        run(8);
        check("t4_count", DW'(hs_log.size()), DW'(6));
        check_hs("t4_b0", 0, 2, 16'h0300, 4'b1000);
        check_hs("t4_b1", 1, 3, 16'h0301, 4'b1000);
        check_hs("t4_b2", 2, 9, 16'h0302, 4'b1000);
        check_hs("t4_b3", 3, 10, 16'h0303, 4'b1000);
        check_hs("t4_b4", 4, 12, 16'h0010, 4'b0001);
        check_hs("t4_b5", 5, 13, 16'h0011, 4'b0001);

        // T5: reset in the middle of input 2's 4-beat packet.
        hs_log.delete();
        load_pkt(2, 0, 4, 1'b0, '0);
        load_pkt(0, 2, 1, 1'b0, '0);
        refresh();
        base = cyc;
        run(3);
        check("t5_pre_count", DW'(hs_log.size()), DW'(2));
        check("t5_pre_grant", DW'(grant_onehot), DW'(4'b0100));
        rst = 1'b1;
        #1;
        check("t5_rst_tvalid", DW'(m_tvalid), DW'(0));
        check("t5_rst_tready", DW'(s_tready), DW'(0));
        check("t5_rst_grant", DW'(grant_onehot), DW'(0));
        check("t5_rst_tdata", m_tdata, '0);
        flush();
        load_pkt(0, 3, 2, 1'b0, '0);
        load_pkt(2, 3, 2, 1'b0, '0);
        refresh();
        step();
        rst = 1'b0;
        base = cyc;
        hs_log.delete();
        run(10);
        check("t5_count", DW'(hs_log.size()), DW'(4));
        check_hs("t5_b0", 0, 2, 16'h0030, 4'b0001);
        check_hs("t5_b1", 1, 3, 16'h0031, 4'b0001);
        check_hs("t5_b2", 2, 5, 16'h0230, 4'b0100);
        check_hs("t5_b3", 3, 6, 16'h0231, 4'b0100);

        // T6: distinctive tuser on input 1 passes unchanged on every beat.
        hs_log.delete();
        load_pkt(1, 4, 3, 1'b1, dead_user);
        refresh();
        base = cyc;
        run(8);
        check("t6_count", DW'(hs_log.size()), DW'(3));
        for (int k = 0; k < 3; k++) begin
            check_hs("t6", k, 2 + k, {8'h01, 4'h4, 4'(k)}, 4'b0010);
            if (k < hs_log.size()) check("t6_tuser", DW'(hs_log[k].user), DW'(dead_user));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
